serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub.sv | 107 ++++++++++
 tb/tb_serial_addsub.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the chunk-serial adder/subtractor.
// The master drives the request fields; the slave returns status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Chunk-serial add/subtract: CHUNK bits per clock over WIDTH/CHUNK cycles.
// Subtraction is a + ~b + ~cin; cout reports a borrow when subtracting.
module serial_addsub #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  // WIDTH must be an integer multiple of CHUNK.
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic             sub_r, carry_r, cout_r, ovf_r;
  logic [KW-1:0]    k_r;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
  logic             c_msb, c_out, last, accept;

  // Bit-level ripple over one chunk; also exposes the carry into the chunk MSB
  // so the final chunk can derive signed overflow.
  function automatic logic [CHUNK+1:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic             c;
    logic             cm;
    logic [CHUNK-1:0] sm;
    c  = ci;
    cm = ci;
    sm = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cm = c;
      sm[i] = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, cm, sm};
  endfunction

  assign accept = (state != RUN) && bus.start;
  assign last   = (k_r == KW'(NCH - 1));
  assign base   = 32'(k_r) * 32'(CHUNK);
  assign a_ch   = CHUNK'(a_r >> base);
  assign b_ch   = CHUNK'(b_r >> base);
  assign {c_out, c_msb, sum_ch} = chunk_add(a_ch, b_ch, carry_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = bus.start ? RUN : IDLE;
      RUN:        if (last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Operand capture: only on an accepted start, so later input wiggles are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r   <= bus.a;
      b_r   <= bus.sub ? ~bus.b : bus.b;
      sub_r <= bus.sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r     <= '0;
      carry_r <= 1'b0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      k_r     <= '0;
      carry_r <= bus.cin ^ bus.sub;
    end else if (state == RUN) begin
      s_r     <= (s_r & ~(CMASK << base)) | (WIDTH'(sum_ch) << base);
      carry_r <= c_out;
      k_r     <= k_r + KW'(1);
      if (last) begin
        cout_r <= c_out ^ sub_r;
        ovf_r  <= c_msb ^ c_out;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: a 12-bit/3-bit-chunk instance and a
// 6-bit single-chunk instance, directed vectors plus model-checked random ops.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(12)) b12();
  serial_addsub_if #(.WIDTH(6))  b6();

  serial_addsub #(.WIDTH(12), .CHUNK(3)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12.slave));
  serial_addsub #(.WIDTH(6),  .CHUNK(6)) u6  (.clk(clk), .rst_n(rst_n), .bus(b6.slave));

  typedef struct {
    logic [11:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q12[$];
  exp_t q6[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic busy_of(input int w);
    return (w == 12) ? b12.busy : b6.busy;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 12) ? b12.done : b6.done;
  endfunction

  // Reference arithmetic on plain integers; borrow is a < b + cin.
  function automatic void model(input int w, input bit sb, input int unsigned x,
                                input int unsigned y, input bit ci,
                                output int unsigned rs, output bit rc, output bit ro);
    int unsigned mask, msb, t;
    mask = (32'd1 << w) - 1;
    msb  = 32'd1 << (w - 1);
    if (!sb) begin
      t  = x + y + ci;
      rs = t & mask;
      rc = ((t >> w) & 1) != 0;
      ro = ((x & msb) == (y & msb)) && ((rs & msb) != (x & msb));
    end else begin
      rs = (x - y - ci) & mask;
      rc = x < (y + ci);
      ro = ((x & msb) != (y & msb)) && ((rs & msb) != (x & msb));
    end
  endfunction

  task automatic drive(input int w, input bit st, input bit sb, input logic [11:0] x,
                       input logic [11:0] y, input bit ci);
    if (w == 12) begin
      b12.start = st; b12.sub = sb; b12.a = x; b12.b = y; b12.cin = ci;
    end else begin
      b6.start = st; b6.sub = sb; b6.a = x[5:0]; b6.b = y[5:0]; b6.cin = ci;
    end
  endtask

  task automatic issue(input int w, input bit sb, input logic [11:0] x, input logic [11:0] y,
                       input bit ci, input logic [11:0] es, input bit ec, input bit eo);
    exp_t e;
    e.s = es; e.c = ec; e.o = eo;
    if (w == 12) q12.push_back(e);
    else         q6.push_back(e);
    drive(w, 1'b1, sb, x, y, ci);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
  endtask

  // Counts edges until done; inputs are scrambled meanwhile and must not matter.
  task automatic waitd(input int w, output int cyc);
    cyc = 0;
    while (done_of(w) !== 1'b1 && cyc < 40) begin
      drive(w, 1'b0, 1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 40) check($sformatf("w%0d done timeout", w), 32'd0, 32'd1);
  endtask

  task automatic run(input int w, input bit sb, input logic [11:0] x, input logic [11:0] y,
                     input bit ci, input logic [11:0] es, input bit ec, input bit eo);
    int cyc;
    int lat;
    lat = (w == 12) ? 4 : 1;
    issue(w, sb, x, y, ci, es, ec, eo);
    check($sformatf("w%0d busy after start", w), 32'(busy_of(w)), 32'd1);
    waitd(w, cyc);
    check($sformatf("w%0d latency", w), cyc, lat);
    check($sformatf("w%0d busy during done", w), 32'(busy_of(w)), 32'd0);
    @(posedge clk); #1;
    check($sformatf("w%0d done single pulse", w), 32'(done_of(w)), 32'd0);
  endtask

  task automatic rand_ops(input int w, input int n);
    int unsigned x, y, rs, mask;
    bit sb, ci, rc, ro;
    mask = (32'd1 << w) - 1;
    for (int i = 0; i < n; i++) begin
      x  = $urandom & mask;
      y  = $urandom & mask;
      sb = 1'($urandom);
      ci = 1'($urandom);
      model(w, sb, x, y, ci, rs, rc, ro);
      run(w, sb, 12'(x), 12'(y), ci, 12'(rs), rc, ro);
    end
  endtask

  always @(negedge clk) begin
    if (b12.done === 1'b1) begin
      if (q12.size() == 0) check("w12 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q12.pop_front();
        check("w12 s", 32'(b12.s), 32'(e.s));
        check("w12 cout", 32'(b12.cout), 32'(e.c));
        check("w12 ovf", 32'(b12.ovf), 32'(e.o));
      end
    end
    if (b6.done === 1'b1) begin
      if (q6.size() == 0) check("w6 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q6.pop_front();
        check("w6 s", 32'(b6.s), 32'(e.s));
        check("w6 cout", 32'(b6.cout), 32'(e.c));
        check("w6 ovf", 32'(b6.ovf), 32'(e.o));
      end
    end
  end

  initial begin
    int cyc, cyc2, dn;
    rst_n = 1'b0;
    drive(12, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    drive(6,  1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    #3;
    check("reset s", 32'(b12.s), 32'd0);
    check("reset cout", 32'(b12.cout), 32'd0);
    check("reset ovf", 32'(b12.ovf), 32'd0);
    check("reset busy", 32'(b12.busy), 32'd0);
    check("reset done", 32'(b12.done), 32'd0);
    check("reset w6 s", 32'(b6.s), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run(12, 1'b0, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    run(12, 1'b0, 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    run(12, 1'b1, 12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1);
    run(12, 1'b1, 12'h005, 12'h007, 1'b1, 12'hFFD, 1'b1, 1'b0);
    run(12, 1'b0, 12'h0A5, 12'h13C, 1'b1, 12'h1E2, 1'b0, 1'b0);
    run(12, 1'b1, 12'h123, 12'h456, 1'b0, 12'hCCD, 1'b1, 1'b0);

    // start during RUN carries conflicting operands and must be dropped
    issue(12, 1'b0, 12'h111, 12'h222, 1'b0, 12'h333, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(12, 1'b1, 1'b1, 12'hFFF, 12'hFFF, 1'b1);
    @(posedge clk); #1;
    drive(12, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    waitd(12, cyc);
    check("ignored start latency", 2 + cyc, 4);
    @(posedge clk); #1;
    check("ignored start no rerun", 32'(b12.busy), 32'd0);

    // back-to-back: second start lands in the DONE cycle
    issue(12, 1'b0, 12'h400, 12'h400, 1'b0, 12'h800, 1'b0, 1'b1);
    waitd(12, cyc);
    check("b2b first latency", cyc, 4);
    issue(12, 1'b1, 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0);
    waitd(12, cyc2);
    check("b2b done spacing", 1 + cyc2, 5);
    @(posedge clk); #1;

    // asynchronous abort after two chunks
    drive(12, 1'b1, 1'b0, 12'h123, 12'h456, 1'b0);
    @(posedge clk); #1;
    drive(12, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("abort s", 32'(b12.s), 32'd0);
    check("abort cout", 32'(b12.cout), 32'd0);
    check("abort ovf", 32'(b12.ovf), 32'd0);
    check("abort busy", 32'(b12.busy), 32'd0);
    check("abort done", 32'(b12.done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b12.done === 1'b1) dn++;
    end
    check("abort no done", dn, 0);
    run(12, 1'b0, 12'h001, 12'h002, 1'b0, 12'h003, 1'b0, 1'b0);

    run(6, 1'b0, 12'h03F, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    run(6, 1'b0, 12'h01F, 12'h001, 1'b0, 12'h020, 1'b0, 1'b1);
    run(6, 1'b1, 12'h020, 12'h001, 1'b0, 12'h01F, 1'b0, 1'b1);
    run(6, 1'b1, 12'h000, 12'h000, 1'b1, 12'h03F, 1'b1, 1'b0);
    run(6, 1'b0, 12'h02A, 12'h015, 1'b1, 12'h000, 1'b1, 1'b0);

    rand_ops(12, 300);
    rand_ops(6, 300);

    repeat (3) @(posedge clk);
    #1;
    check("w12 scoreboard drained", q12.size(), 0);
    check("w6 scoreboard drained", q6.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
